hazard_unit: RTL and testbench

HAZARD_UNIT -- requirements
Module: hazard_unit

---
 rtl/hazard_pkg.sv | 23 ++
 rtl/hazard_dep_check.sv | 27 ++
 rtl/hazard_unit.sv | 135 +++++++++++++
 tb/tb_hazard_unit.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared constants and FSM encoding for the pipeline hazard unit.
package hazard_pkg;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpSw    = 6'h2B;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;

  // Write-back source code selecting data memory (a load).
  localparam logic [1:0] WbLoad = 2'b01;

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StLuStall = 2'd1,
    StMemWait = 2'd2
  } hz_state_e;

  // Opcodes whose rt field is a source operand rather than a destination.
  function automatic logic op_uses_rt(input logic [5:0] op);
    return (op == OpRtype) || (op == OpSw) || (op == OpBeq) || (op == OpBne);
  endfunction

endpackage

// File: rtl/hazard_dep_check.sv
// Load-use dependency comparator between the instruction in ID and a load in EXE.
module hazard_dep_check
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW = 5
) (
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic [5:0]        id_op_i,
  input  logic [REG_AW-1:0] exe_num_write_i,
  input  logic              exe_reg_write_i,
  input  logic [1:0]        exe_s_data_write_i,
  output logic              load_use_o
);

  logic exe_is_load;
  logic rs_hit;
  logic rt_hit;

  // r0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign exe_is_load = exe_reg_write_i && (exe_s_data_write_i == WbLoad) &&
                       (exe_num_write_i != '0);
  assign rs_hit      = (exe_num_write_i == id_rs_i);
  assign rt_hit      = op_uses_rt(id_op_i) && (exe_num_write_i == id_rt_i);
  assign load_use_o  = exe_is_load && (rs_hit || rt_hit);

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: load-use bubbles, memory-wait freeze and branch flush.
// Define HAZARD_PERF_EN to add stall_cycles / flush_events performance counters.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned LOAD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [5:0]        id_op,
  input  logic [REG_AW-1:0] exe_num_write,
  input  logic              exe_reg_write,
  input  logic [1:0]        exe_s_data_write,
  input  logic              exe_branch_taken,
  input  logic              mem_req,
  input  logic              mem_ready,
  output logic              pc_stall,
  output logic              if_id_stall,
  output logic              id_exe_stall,
  output logic              exe_mem_stall,
  output logic              if_id_flush,
  output logic              id_exe_flush,
  output logic [1:0]        hz_state
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]       stall_cycles,
  output logic [31:0]       flush_events
`endif
);

  localparam logic [1:0] LuInit = 2'(LOAD_LAT - 1);

  hz_state_e  state_q, state_d;
  hz_state_e  saved_q, saved_d;
  hz_state_e  eff_state;
  logic [1:0] cnt_q, cnt_d;
  logic       load_use;
  logic       mem_wait;

  hazard_dep_check #(
    .REG_AW(REG_AW)
  ) u_dep_check (
    .id_rs_i           (id_rs),
    .id_rt_i           (id_rt),
    .id_op_i           (id_op),
    .exe_num_write_i   (exe_num_write),
    .exe_reg_write_i   (exe_reg_write),
    .exe_s_data_write_i(exe_s_data_write),
    .load_use_o        (load_use)
  );

  assign mem_wait  = mem_req && !mem_ready;
  // On release from a memory wait, act this cycle as the interrupted state would.
  assign eff_state = (state_q == StMemWait) ? saved_q : state_q;

  always_comb begin
    state_d       = state_q;
    saved_d       = saved_q;
    cnt_d         = cnt_q;
    pc_stall      = 1'b0;
    if_id_stall   = 1'b0;
    id_exe_stall  = 1'b0;
    exe_mem_stall = 1'b0;
    if_id_flush   = 1'b0;
    id_exe_flush  = 1'b0;
    if (rst) begin
      state_d = StRun;
    end else if (mem_wait) begin
      pc_stall      = 1'b1;
      if_id_stall   = 1'b1;
      id_exe_stall  = 1'b1;
      exe_mem_stall = 1'b1;
      state_d       = StMemWait;
      if (state_q != StMemWait) saved_d = state_q;
    end else begin
      state_d = eff_state;
      if (exe_branch_taken) begin
        if_id_flush  = 1'b1;
        id_exe_flush = 1'b1;
        state_d      = StRun;
        cnt_d        = 2'd0;
      end else if (eff_state == StLuStall) begin
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        id_exe_flush = 1'b1;
        cnt_d        = cnt_q - 2'd1;
        if (cnt_q == 2'd1) state_d = StRun;
      end else if (load_use) begin
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        id_exe_flush = 1'b1;
        if (LOAD_LAT > 1) begin
          state_d = StLuStall;
          cnt_d   = LuInit;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StRun;
      saved_q <= StRun;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      saved_q <= saved_d;
      cnt_q   <= cnt_d;
    end
  end

  assign hz_state = state_q;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles_q;
  logic [31:0] flush_events_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_q <= 32'd0;
      flush_events_q <= 32'd0;
    end else begin
      if (pc_stall)     stall_cycles_q <= stall_cycles_q + 32'd1;
      if (id_exe_flush) flush_events_q <= flush_events_q + 32'd1;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_events = flush_events_q;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: three instances (LOAD_LAT 1..3) against a bubble-count model.
module tb_hazard_unit;

  localparam int unsigned AW   = 5;
  localparam int          NDUT = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] id_rs, id_rt, exe_num_write;
  logic [5:0]    id_op;
  logic          exe_reg_write;
  logic [1:0]    exe_s_data_write;
  logic          exe_branch_taken, mem_req, mem_ready;

  logic [NDUT-1:0] pc_stall, if_id_stall, id_exe_stall, exe_mem_stall;
  logic [NDUT-1:0] if_id_flush, id_exe_flush;
  logic [1:0]      hz_state [NDUT];
`ifdef HAZARD_PERF_EN
  logic [31:0]     stall_cycles [NDUT];
  logic [31:0]     flush_events [NDUT];
`endif

  int          n_checks = 0;
  int          n_errors = 0;
  int          rem [NDUT];
  bit          waiting;
  int          seen_stall [NDUT];
  logic [31:0] m_stall [NDUT];
  logic [31:0] m_flush [NDUT];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    hazard_unit #(
      .REG_AW  (AW),
      .LOAD_LAT(g + 1)
    ) u_dut (
      .clk             (clk),
      .rst             (rst),
      .id_rs           (id_rs),
      .id_rt           (id_rt),
      .id_op           (id_op),
      .exe_num_write   (exe_num_write),
      .exe_reg_write   (exe_reg_write),
      .exe_s_data_write(exe_s_data_write),
      .exe_branch_taken(exe_branch_taken),
      .mem_req         (mem_req),
      .mem_ready       (mem_ready),
      .pc_stall        (pc_stall[g]),
      .if_id_stall     (if_id_stall[g]),
      .id_exe_stall    (id_exe_stall[g]),
      .exe_mem_stall   (exe_mem_stall[g]),
      .if_id_flush     (if_id_flush[g]),
      .id_exe_flush    (id_exe_flush[g]),
      .hz_state        (hz_state[g])
`ifdef HAZARD_PERF_EN
      ,
      .stall_cycles    (stall_cycles[g]),
      .flush_events    (flush_events[g])
`endif
    );
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Load-use straight from the rules: loaded register read by the ID instruction.
  function automatic bit model_lu();
    bit reads_rt;
    reads_rt = (id_op == 6'h00) || (id_op == 6'h2B) || (id_op == 6'h04) || (id_op == 6'h05);
    return exe_reg_write && (exe_s_data_write == 2'b01) && (exe_num_write != 0) &&
           ((exe_num_write == id_rs) || (reads_rt && (exe_num_write == id_rt)));
  endfunction

  // {pc, if_id_stall, id_exe_stall, exe_mem_stall, if_id_flush, id_exe_flush, hz_state}
  function automatic logic [7:0] model_out(int k);
    logic [1:0] hz;
    hz = waiting ? 2'd2 : ((rem[k] > 0) ? 2'd1 : 2'd0);
    if (rst) return 8'h00;
    if (mem_req && !mem_ready) return {6'b111100, hz};
    if (exe_branch_taken) return {6'b000011, hz};
    if ((rem[k] > 0) || model_lu()) return {6'b110001, hz};
    return {6'b000000, hz};
  endfunction

  task automatic step();
    logic [7:0] got, exp;
    bit         mw, lu;
    #2;
    if (rst) begin
      for (int k = 0; k < NDUT; k++) begin
        rem[k] = 0; m_stall[k] = 0; m_flush[k] = 0;
      end
      waiting = 0;
    end
    for (int k = 0; k < NDUT; k++) begin
      exp = model_out(k);
      got = {pc_stall[k], if_id_stall[k], id_exe_stall[k], exe_mem_stall[k],
             if_id_flush[k], id_exe_flush[k], hz_state[k]};
      check_eq($sformatf("dut%0d_out", k + 1), 32'(got), 32'(exp));
      if (pc_stall[k]) seen_stall[k]++;
`ifdef HAZARD_PERF_EN
      check_eq($sformatf("dut%0d_stall_cycles", k + 1), stall_cycles[k], m_stall[k]);
      check_eq($sformatf("dut%0d_flush_events", k + 1), flush_events[k], m_flush[k]);
`endif
    end
    @(posedge clk);
    mw = mem_req && !mem_ready;
    lu = model_lu();
    for (int k = 0; k < NDUT; k++) begin
      if (rst) begin
        rem[k] = 0; m_stall[k] = 0; m_flush[k] = 0;
      end else begin
        exp = model_out(k);
        if (exp[7]) m_stall[k]++;
        if (exp[2]) m_flush[k]++;
        if (!mw) begin
          if (exe_branch_taken) rem[k] = 0;
          else if (rem[k] > 0) rem[k]--;
          else if (lu) rem[k] = k;
        end
      end
    end
    waiting = !rst && mw;
    #1;
  endtask

  task automatic drive(input int rs, input int rt, input logic [5:0] op, input int num,
                       input bit rw, input logic [1:0] sdw, input bit br, input bit mreq,
                       input bit mrdy);
    id_rs = AW'(rs); id_rt = AW'(rt); id_op = op; exe_num_write = AW'(num);
    exe_reg_write = rw; exe_s_data_write = sdw; exe_branch_taken = br;
    mem_req = mreq; mem_ready = mrdy;
  endtask

  task automatic nop();
    drive(0, 0, 6'h00, 0, 0, 2'b00, 0, 0, 0);
  endtask

  task automatic clear_seen();
    for (int k = 0; k < NDUT; k++) seen_stall[k] = 0;
  endtask

  logic [5:0] ops [6] = '{6'h00, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h23};

  initial begin
    rst = 1'b1;
    waiting = 0;
    for (int k = 0; k < NDUT; k++) begin
      rem[k] = 0; m_stall[k] = 0; m_flush[k] = 0; seen_stall[k] = 0;
    end
    nop();
    // Reset state, even with a pending memory wait on the inputs.
    step();
    drive(0, 0, 6'h00, 0, 0, 2'b00, 1, 1, 0);
    step();
    nop();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Load r8 then R-type reading r8: bubble lengths follow LOAD_LAT.
    clear_seen();
    drive(8, 0, 6'h00, 8, 1, 2'b01, 0, 0, 0);
    step();
    nop();
    repeat (4) step();
    check_eq("lu_len_lat1", seen_stall[0], 1);
    check_eq("lu_len_lat2", seen_stall[1], 2);
    check_eq("lu_len_lat3", seen_stall[2], 3);

    // addi writes rt, so rt=r9 is not a source.
    drive(2, 9, 6'h08, 9, 1, 2'b01, 0, 0, 0);
    step();
    check_eq("addi_rt_nostall", 32'(pc_stall), 0);
    clear_seen();
    drive(2, 9, 6'h2B, 9, 1, 2'b01, 0, 0, 0);
    step();
    nop();
    repeat (3) step();
    check_eq("sw_rt_lat3", seen_stall[2], 3);

    // Load to r0 never stalls.
    drive(0, 0, 6'h00, 0, 1, 2'b01, 0, 0, 0);
    step();
    check_eq("r0_nostall", 32'(pc_stall), 0);
    nop();
    step();

    // Load-use then a 4-cycle memory wait, then the remaining bubble.
    clear_seen();
    drive(8, 0, 6'h00, 8, 1, 2'b01, 0, 0, 0);
    step();
    drive(0, 0, 6'h00, 0, 0, 2'b00, 0, 1, 0);
    repeat (4) step();
    check_eq("wait_flush_low", 32'(id_exe_flush | if_id_flush), 0);
    drive(0, 0, 6'h00, 0, 0, 2'b00, 0, 1, 1);
    step();
    nop();
    step();
    check_eq("wait_lat2_stalls", seen_stall[1], 6);

    // Branch overrides a simultaneous load-use.
    drive(8, 0, 6'h00, 8, 1, 2'b01, 1, 0, 0);
    step();
    check_eq("br_lu_pc_stall", 32'(pc_stall), 0);
    check_eq("br_lu_flushes", 32'({if_id_flush, id_exe_flush}), 32'h3f);
    nop();
    step();

    // Asynchronous reset in the middle of a load-use stall.
    drive(8, 0, 6'h00, 8, 1, 2'b01, 0, 0, 0);
    step();
    nop();
    rst = 1'b1;
    step();
    check_eq("rst_mid_stall", 32'(pc_stall), 0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 63) == 0);
      drive($urandom_range(0, 3), $urandom_range(0, 3), ops[$urandom_range(0, 5)],
            $urandom_range(0, 3), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 1)));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
